// File: rtl/vcve2_pkg.sv
// vcve2 shared types for the VRF port sequencer.
// State encodings for the global sequencer and the per-port engines.
package vcve2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } vrf_seq_state_e;

  typedef enum logic [2:0] {
    P_IDLE,
    P_WAIT,
    P_REQ,
    P_RESP,
    P_DONE
  } vrf_port_state_e;

  localparam int unsigned VRF_WORD_BYTES = 4;

endpackage

// File: rtl/vcve2_vrf_port_fsm.sv
// vcve2 per-port VRF transfer engine.
// Walks words p, p+N, p+2N... with one outstanding access at a time.
module vcve2_vrf_port_fsm
  import vcve2_pkg::*;
#(
  parameter int unsigned PortIdx       = 0,
  parameter int unsigned NumPorts      = 2,
  parameter int unsigned StaggerCycles = 1,
  parameter int unsigned NW            = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          finish_i,
  input  logic          we_i,
  input  logic [31:0]   base_addr_i,
  input  logic [NW-1:0] num_words_i,
  input  logic [31:0]   wdata_i,
  input  logic          gnt_i,
  input  logic          rvalid_i,
  input  logic          err_i,
  input  logic [31:0]   rdata_i,
  output logic          req_o,
  output logic [31:0]   addr_o,
  output logic          we_o,
  output logic [31:0]   wdata_o,
  output logic          wdata_ack_o,
  output logic [31:0]   rdata_o,
  output logic          rvalid_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int unsigned IW = NW + 4;
  localparam logic [IW-1:0] IdxInit  = IW'(PortIdx);
  localparam logic [IW-1:0] IdxStep  = IW'(NumPorts);
  localparam logic [31:0]   AddrInit = 32'(PortIdx * VRF_WORD_BYTES);
  localparam logic [31:0]   AddrStep = 32'(NumPorts * VRF_WORD_BYTES);
  localparam logic [15:0]   WaitCyc  = 16'(PortIdx * StaggerCycles);

  vrf_port_state_e r_state;
  logic [15:0]     r_cnt;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_num;
  logic [31:0]     r_addr;
  logic [31:0]     r_rdata;
  logic            r_we;
  logic            r_rvalid;

  logic [IW-1:0]   w_num;
  logic [IW-1:0]   w_next;
  logic            w_owns;
  logic            w_more;

  assign w_num  = IW'(num_words_i);
  assign w_owns = w_num > IdxInit;
  assign w_next = r_idx + IdxStep;
  assign w_more = w_next < r_num;

  assign req_o       = r_state == P_REQ;
  assign addr_o      = r_addr;
  assign we_o        = r_we;
  assign wdata_o     = req_o ? wdata_i : '0;
  assign wdata_ack_o = req_o & gnt_i & r_we;
  assign rdata_o     = r_rdata;
  assign rvalid_o    = r_rvalid;
  assign done_o      = r_state == P_DONE;
  assign err_o       = (r_state == P_RESP) & rvalid_i & err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= P_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_num    <= '0;
      r_addr   <= '0;
      r_rdata  <= '0;
      r_we     <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      unique case (r_state)
        P_IDLE: begin
          if (start_i) begin
            r_we   <= we_i;
            r_num  <= w_num;
            r_idx  <= IdxInit;
            r_addr <= base_addr_i + AddrInit;
            r_cnt  <= WaitCyc;
            if (!w_owns) begin
              r_state <= P_DONE;
            end else if (WaitCyc == 16'd0) begin
              r_state <= P_REQ;
            end else begin
              r_state <= P_WAIT;
            end
          end
        end
        P_WAIT: begin
          r_cnt <= r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            r_state <= P_REQ;
          end
        end
        P_REQ: begin
          if (gnt_i) begin
            r_state <= P_RESP;
          end
        end
        P_RESP: begin
          if (rvalid_i) begin
            // An errored response abandons the rest of this port's words
            if (err_i) begin
              r_state <= P_DONE;
            end else begin
              if (!r_we) begin
                r_rdata  <= rdata_i;
                r_rvalid <= 1'b1;
              end
              if (w_more) begin
                r_idx   <= w_next;
                r_addr  <= r_addr + AddrStep;
                r_state <= P_REQ;
              end else begin
                r_state <= P_DONE;
              end
            end
          end
        end
        P_DONE: begin
          if (finish_i) begin
            r_state <= P_IDLE;
          end
        end
        default: r_state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vcve2_vrf_port_sequencer.sv
// vcve2 VRF port sequencer top: global FSM, port barrier, error OR.
// One register-group access is striped word-wise across NumPorts ports.
module vcve2_vrf_port_sequencer
  import vcve2_pkg::*;
#(
  parameter int unsigned NumPorts      = 2,
  parameter int unsigned MaxWords      = 32,
  parameter int unsigned StaggerCycles = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         we_i,
  input  logic [31:0]                  base_addr_i,
  input  logic [$clog2(MaxWords):0]    num_words_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  input  logic [NumPorts*32-1:0]       wdata_i,
  output logic [NumPorts-1:0]          wdata_ack_o,
  output logic [NumPorts*32-1:0]       rdata_o,
  output logic [NumPorts-1:0]          rvalid_o,
  output logic [NumPorts-1:0]          data_req_o,
  input  logic [NumPorts-1:0]          data_gnt_i,
  input  logic [NumPorts-1:0]          data_rvalid_i,
  input  logic [NumPorts-1:0]          data_err_i,
  output logic [NumPorts*32-1:0]       data_addr_o,
  output logic [NumPorts-1:0]          data_we_o,
  output logic [NumPorts*4-1:0]        data_be_o,
  output logic [NumPorts*32-1:0]       data_wdata_o,
  input  logic [NumPorts*32-1:0]       data_rdata_i
);

  localparam int unsigned NW = $clog2(MaxWords) + 1;

  vrf_seq_state_e      r_state;
  logic                r_err;
  logic                w_start;
  logic                w_finish;
  logic [NW-1:0]       w_num;
  logic [NumPorts-1:0] w_pdone;
  logic [NumPorts-1:0] w_perr;

  assign w_start  = start_i & (r_state == IDLE);
  assign w_finish = r_state == FINISH;
  assign w_num    = (num_words_i > NW'(MaxWords)) ? NW'(MaxWords) : num_words_i;

  assign busy_o = r_state != IDLE;
  assign done_o = w_finish;
  assign err_o  = r_err;

  for (genvar gp = 0; gp < NumPorts; gp++) begin : g_port
    vcve2_vrf_port_fsm #(
      .PortIdx      (gp),
      .NumPorts     (NumPorts),
      .StaggerCycles(StaggerCycles),
      .NW           (NW)
    ) u_port (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (w_start),
      .finish_i   (w_finish),
      .we_i       (we_i),
      .base_addr_i(base_addr_i),
      .num_words_i(w_num),
      .wdata_i    (wdata_i[gp*32 +: 32]),
      .gnt_i      (data_gnt_i[gp]),
      .rvalid_i   (data_rvalid_i[gp]),
      .err_i      (data_err_i[gp]),
      .rdata_i    (data_rdata_i[gp*32 +: 32]),
      .req_o      (data_req_o[gp]),
      .addr_o     (data_addr_o[gp*32 +: 32]),
      .we_o       (data_we_o[gp]),
      .wdata_o    (data_wdata_o[gp*32 +: 32]),
      .wdata_ack_o(wdata_ack_o[gp]),
      .rdata_o    (rdata_o[gp*32 +: 32]),
      .rvalid_o   (rvalid_o[gp]),
      .done_o     (w_pdone[gp]),
      .err_o      (w_perr[gp])
    );
    assign data_be_o[gp*4 +: 4] = 4'hF;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE:    if (w_start) r_state <= RUN;
        RUN:     if (&w_pdone) r_state <= FINISH;
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_start) begin
        r_err <= 1'b0;
      end else if (|w_perr) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vcve2_vrf_port_sequencer.sv
// Bench for vcve2_vrf_port_sequencer: random-stall memory per port,
// expected word/address streams built from the striping rule.
module tb_vcve2_vrf_port_sequencer;

  localparam int NP = 3;
  localparam int MW = 32;
  localparam int ST = 2;
  localparam int NW = $clog2(MW) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              t_start = 1'b0;
  logic              t_we = 1'b0;
  logic [31:0]       t_base = '0;
  logic [NW-1:0]     t_num = '0;
  logic              busy, done, err;
  logic [NP*32-1:0]  wdata;
  logic [NP-1:0]     wack;
  logic [NP*32-1:0]  rdata_o;
  logic [NP-1:0]     rvalid_o;
  logic [NP-1:0]     req;
  logic [NP-1:0]     gnt = '0;
  logic [NP-1:0]     rvalid = '0;
  logic [NP-1:0]     derr = '0;
  logic [NP*32-1:0]  daddr;
  logic [NP-1:0]     dwe;
  logic [NP*4-1:0]   dbe;
  logic [NP*32-1:0]  dwdata;
  logic [NP*32-1:0]  rdata_in = '0;

  always #5 clk = ~clk;

  vcve2_vrf_port_sequencer #(
    .NumPorts(NP), .MaxWords(MW), .StaggerCycles(ST)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(t_start), .we_i(t_we),
    .base_addr_i(t_base), .num_words_i(t_num),
    .busy_o(busy), .done_o(done), .err_o(err),
    .wdata_i(wdata), .wdata_ack_o(wack), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .data_req_o(req), .data_gnt_i(gnt),
    .data_rvalid_i(rvalid), .data_err_i(derr), .data_addr_o(daddr),
    .data_we_o(dwe), .data_be_o(dbe), .data_wdata_o(dwdata),
    .data_rdata_i(rdata_in)
  );

  function automatic logic [31:0] wfun(logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  function automatic logic [31:0] rfun(logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  // Write data follows the address the port is presenting
  always_comb begin
    wdata = '0;
    for (int p = 0; p < NP; p++) wdata[p*32 +: 32] = wfun(daddr[p*32 +: 32]);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int gmax = 0;
  int rmax = 0;
  int err_port = -1;
  int err_k = 0;

  int          m_st[NP];
  int          m_cnt[NP];
  int          m_rsp[NP];
  bit          m_hold[NP];
  logic [31:0] m_addr[NP];
  logic [31:0] m_wd[NP];
  logic        m_we[NP];

  logic [31:0] o_addr[NP][$];
  logic [31:0] o_wd[NP][$];
  logic        o_we[NP][$];
  logic [31:0] o_rd[NP][$];
  int          o_first[NP];
  int          o_ack, o_done, o_done_cyc, o_unstable, o_gnt_done;

  logic [31:0] e_addr[NP][$];
  logic        e_we;

  function automatic int n_granted();
    int s = 0;
    for (int p = 0; p < NP; p++) s += o_addr[p].size();
    return s;
  endfunction

  function automatic int n_expected();
    int s = 0;
    for (int p = 0; p < NP; p++) s += e_addr[p].size();
    return s;
  endfunction

  // Memory: random grant/response latency, logs what each port presents
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        m_st[p] = 0; m_cnt[p] = 0; m_hold[p] = 0;
      end
      gnt = '0; rvalid = '0; derr = '0;
    end else begin
      if (done) begin
        o_done++; o_done_cyc = cyc; o_gnt_done = n_granted();
      end
      for (int p = 0; p < NP; p++) begin
        if (rvalid_o[p]) o_rd[p].push_back(rdata_o[p*32 +: 32]);
        if (req[p] && o_first[p] < 0) o_first[p] = cyc;
        gnt[p] = 1'b0; rvalid[p] = 1'b0; derr[p] = 1'b0;
        if (m_st[p] == 0 && req[p]) begin
          if (!m_hold[p]) begin
            m_hold[p] = 1; m_addr[p] = daddr[p*32 +: 32];
            m_wd[p] = dwdata[p*32 +: 32]; m_we[p] = dwe[p];
          end else if (daddr[p*32 +: 32] !== m_addr[p] ||
                       dwdata[p*32 +: 32] !== m_wd[p] || dwe[p] !== m_we[p]) begin
            o_unstable++;
          end
          if (m_cnt[p] == 0) begin
            gnt[p] = 1'b1; m_hold[p] = 0;
            o_addr[p].push_back(m_addr[p]);
            o_wd[p].push_back(m_wd[p]);
            o_we[p].push_back(m_we[p]);
            m_st[p] = 1; m_cnt[p] = $urandom_range(0, rmax);
          end else begin
            m_cnt[p]--;
          end
        end else if (m_st[p] == 1) begin
          if (m_cnt[p] == 0) begin
            rvalid[p] = 1'b1;
            rdata_in[p*32 +: 32] = rfun(m_addr[p]);
            derr[p] = (p == err_port) && (m_rsp[p] == err_k);
            m_rsp[p]++;
            m_st[p] = 0; m_cnt[p] = $urandom_range(0, gmax);
          end else begin
            m_cnt[p]--;
          end
        end
      end
      #1;
      for (int p = 0; p < NP; p++) if (wack[p]) o_ack++;
    end
  end

  function automatic int stream_bad();
    int bad = 0;
    for (int p = 0; p < NP; p++) begin
      if (o_addr[p].size() != e_addr[p].size()) begin
        bad++;
      end else begin
        for (int i = 0; i < e_addr[p].size(); i++) begin
          if (o_addr[p][i] !== e_addr[p][i]) bad++;
          if (o_we[p][i] !== e_we) bad++;
          if (e_we && o_wd[p][i] !== wfun(e_addr[p][i])) bad++;
        end
      end
      if (e_we) begin
        if (o_rd[p].size() != 0) bad++;
      end else if (err_port < 0) begin
        if (o_rd[p].size() != e_addr[p].size()) bad++;
        else for (int i = 0; i < o_rd[p].size(); i++)
          if (o_rd[p][i] !== rfun(e_addr[p][i])) bad++;
      end
    end
    return bad;
  endfunction

  function automatic int stagger_bad();
    int bad = 0;
    for (int p = 0; p < NP; p++) begin
      if (e_addr[p].size() > 0) begin
        if (o_first[p] - c0 != 1 + p * ST) bad++;
      end else if (o_first[p] != -1) begin
        bad++;
      end
    end
    return bad;
  endfunction

  task automatic do_op(input logic w, input logic [31:0] b, input int n,
                       input bit poke);
    int ns;
    for (int p = 0; p < NP; p++) begin
      o_addr[p].delete(); o_wd[p].delete(); o_we[p].delete();
      o_rd[p].delete(); e_addr[p].delete();
      o_first[p] = -1; m_rsp[p] = 0;
    end
    o_ack = 0; o_done = 0; o_done_cyc = -1; o_unstable = 0; o_gnt_done = -1;
    ns = (n > MW) ? MW : n;
    for (int i = 0; i < ns; i++) e_addr[i % NP].push_back(b + 32'(4 * i));
    if (err_port >= 0)
      while (e_addr[err_port].size() > err_k + 1) void'(e_addr[err_port].pop_back());
    e_we = w;
    @(negedge clk); #2;
    t_start = 1'b1; t_we = w; t_base = b; t_num = NW'(n); c0 = cyc;
    @(negedge clk); #2;
    t_start = 1'b0; t_we = 1'($urandom); t_base = $urandom; t_num = NW'($urandom);
    for (int i = 0; i < 4000 && o_done == 0; i++) begin
      @(negedge clk); #2;
      t_start = poke && (i == 3);
    end
    repeat (4) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (req !== '0) begin errors++; $display("FAIL reset_req got %b want 0", req); end
    checks++; if ({rvalid_o, wack} !== '0) begin errors++; $display("FAIL reset_valids got %b want 0", {rvalid_o, wack}); end
  endtask

  task automatic test_read_basic();
    gmax = 0; rmax = 0;
    do_op(1'b0, 32'h1000, 4, 1'b0);
    checks++; if (stream_bad() !== 0) begin errors++; $display("FAIL read_stream got %0d bad want 0", stream_bad()); end
    checks++; if (o_done !== 1) begin errors++; $display("FAIL read_done got %0d pulses want 1", o_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err got %b want 0", err); end
    checks++; if (stagger_bad() !== 0) begin errors++; $display("FAIL read_stagger got %0d bad want 0", stagger_bad()); end
    checks++; if (o_ack !== 0) begin errors++; $display("FAIL read_ack got %0d want 0", o_ack); end
  endtask

  task automatic test_write_stagger();
    do_op(1'b1, 32'h2000, 5, 1'b0);
    checks++; if (o_ack !== 5) begin errors++; $display("FAIL wr_ack got %0d want 5", o_ack); end
    checks++; if (stream_bad() !== 0) begin errors++; $display("FAIL wr_stream got %0d bad want 0", stream_bad()); end
    checks++; if (o_first[2] - o_first[0] !== 2 * ST) begin errors++; $display("FAIL wr_p2_delay got %0d want %0d", o_first[2] - o_first[0], 2 * ST); end
    checks++; if (o_done !== 1) begin errors++; $display("FAIL wr_done got %0d want 1", o_done); end
  endtask

  task automatic test_small_counts();
    do_op(1'b0, 32'h3000, 1, 1'b0);
    checks++; if (stagger_bad() !== 0) begin errors++; $display("FAIL one_word_req got %0d bad want 0", stagger_bad()); end
    checks++; if (stream_bad() !== 0) begin errors++; $display("FAIL one_word_stream got %0d bad want 0", stream_bad()); end
    checks++; if (o_done !== 1) begin errors++; $display("FAIL one_word_done got %0d want 1", o_done); end
    do_op(1'b0, 32'h3000, 0, 1'b0);
    checks++; if (o_done_cyc - c0 !== 2) begin errors++; $display("FAIL zero_done_lat got %0d want 2", o_done_cyc - c0); end
    checks++; if (n_granted() !== 0) begin errors++; $display("FAIL zero_reqs got %0d want 0", n_granted()); end
    do_op(1'b1, 32'h0800, 40, 1'b0);
    checks++; if (n_granted() !== MW) begin errors++; $display("FAIL sat_words got %0d want %0d", n_granted(), MW); end
    checks++; if (stream_bad() !== 0) begin errors++; $display("FAIL sat_stream got %0d bad want 0", stream_bad()); end
  endtask

  task automatic test_error();
    err_port = 1; err_k = 0;
    do_op(1'b1, 32'h5000, 8, 1'b0);
    err_port = -1;
    checks++; if (stream_bad() !== 0) begin errors++; $display("FAIL err_stream got %0d bad want 0", stream_bad()); end
    checks++; if (o_ack !== 6) begin errors++; $display("FAIL err_ack got %0d want 6", o_ack); end
    checks++; if (o_done !== 1) begin errors++; $display("FAIL err_done got %0d want 1", o_done); end
    repeat (5) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    do_op(1'b0, 32'h6000, 2, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
  endtask

  task automatic test_random_stalls();
    logic [31:0] b;
    int n;
    gmax = 5; rmax = 5;
    for (int k = 0; k < 6; k++) begin
      b = $urandom; b[1:0] = 2'b00;
      n = $urandom_range(0, 36);
      if (k == 0) begin b = 32'hFFFF_FFF8; n = 6; end
      do_op(1'($urandom), b, n, 1'b0);
      checks++; if (stream_bad() !== 0) begin errors++; $display("FAIL rnd%0d_stream got %0d bad want 0", k, stream_bad()); end
      checks++; if (o_unstable !== 0) begin errors++; $display("FAIL rnd%0d_stable got %0d changes want 0", k, o_unstable); end
      checks++; if (o_gnt_done !== n_expected()) begin errors++; $display("FAIL rnd%0d_barrier got %0d words want %0d", k, o_gnt_done, n_expected()); end
      checks++; if (stagger_bad() !== 0) begin errors++; $display("FAIL rnd%0d_stagger got %0d bad want 0", k, stagger_bad()); end
    end
  endtask

  task automatic test_reset_mid_run();
    gmax = 5; rmax = 5;
    @(negedge clk); #2;
    t_start = 1'b1; t_we = 1'b0; t_base = 32'h7000; t_num = NW'(30);
    @(negedge clk); #2;
    t_start = 1'b0; o_done = 0;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_async_flags got %b want 000", {busy, done, err}); end
    checks++; if ({req, rvalid_o, wack} !== '0) begin errors++; $display("FAIL rst_async_ports got %b want 0", {req, rvalid_o, wack}); end
    repeat (3) @(negedge clk);
    checks++; if (o_done !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", o_done); end
    #2 rst_n = 1'b1;
    do_op(1'b1, 32'h4000, 6, 1'b0);
    checks++; if (stream_bad() !== 0) begin errors++; $display("FAIL post_rst_stream got %0d bad want 0", stream_bad()); end
    checks++; if (o_done !== 1) begin errors++; $display("FAIL post_rst_done got %0d want 1", o_done); end
  endtask

  task automatic test_start_while_busy();
    do_op(1'b0, 32'h9000, 9, 1'b1);
    checks++; if (stream_bad() !== 0) begin errors++; $display("FAIL busy_start_stream got %0d bad want 0", stream_bad()); end
    checks++; if (o_done !== 1) begin errors++; $display("FAIL busy_start_done got %0d want 1", o_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", busy); end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      o_first[p] = -1; m_rsp[p] = 0; m_st[p] = 0; m_cnt[p] = 0; m_hold[p] = 0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    #2 rst_n = 1'b1;
    test_read_basic();
    test_write_stagger();
    test_small_counts();
    test_error();
    test_random_stalls();
    test_reset_mid_run();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
